// File: rtl/h264_coretransform4x4_if.sv
// h264_coretransform4x4_if: residual-in / coefficient-out bundle for the 4x4 core transform.
// The DC tap signals exist only when H264_CT_DCOUT_EN is defined.
interface h264_coretransform4x4_if;
   logic enable;
   logic [35:0] xxin;
   logic ready;
   logic valid;
   logic [15:0] ynout;
   logic [3:0] index;
`ifdef H264_CT_DCOUT_EN
   logic dcvalid;
   logic [15:0] dcout;
   modport master (output enable, xxin, input ready, valid, ynout, index, dcvalid, dcout);
   modport slave (input enable, xxin, output ready, valid, ynout, index, dcvalid, dcout);
`else
   modport master (output enable, xxin, input ready, valid, ynout, index);
   modport slave (input enable, xxin, output ready, valid, ynout, index);
`endif
endinterface

// File: rtl/h264_coretransform4x4.sv
// h264_coretransform4x4: double-banked forward 4x4 H.264 core transform, rows in, coefficients out in raster order.
// Optional DC tap (dcvalid/dcout) is built when H264_CT_DCOUT_EN is defined.
module h264_coretransform4x4 (
   input logic clk,
   input logic reset,
   h264_coretransform4x4_if.slave bus
);
   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_t;
   typedef enum logic {RD_IDLE, RD_RUN} rd_t;
   bank_t st [2];
   bank_t st_nx [2];
   rd_t rd, rd_nx;
   logic [1:0] rowcnt;
   logic wbank, rbank, rbank_nx, sel, o;
   logic [3:0] k, k_nx;
   logic [11:0] mem [2][4][4];
   logic signed [11:0] x0, x1, x2, x3, ha, hb, hc, hd;
   logic signed [11:0] h [4];
   logic signed [14:0] v0, v1, v2, v3, va, vb, vc, vd, y;
   logic ready_int, accept, fill_done, drain_done, start_idle, chain;
   assign bus.ready = ready_int;
   always_comb begin
      x0 = {{3{bus.xxin[8]}}, bus.xxin[8:0]};
      x1 = {{3{bus.xxin[17]}}, bus.xxin[17:9]};
      x2 = {{3{bus.xxin[26]}}, bus.xxin[26:18]};
      x3 = {{3{bus.xxin[35]}}, bus.xxin[35:27]};
      ha = x0 + x3;
      hb = x1 + x2;
      hc = x1 - x2;
      hd = x0 - x3;
      h[0] = ha + hb;
      h[1] = (hd <<< 1) + hc;
      h[2] = ha - hb;
      h[3] = hd - (hc <<< 1);
   end
   always_comb begin
      v0 = {{3{mem[rbank][0][k[1:0]][11]}}, mem[rbank][0][k[1:0]]};
      v1 = {{3{mem[rbank][1][k[1:0]][11]}}, mem[rbank][1][k[1:0]]};
      v2 = {{3{mem[rbank][2][k[1:0]][11]}}, mem[rbank][2][k[1:0]]};
      v3 = {{3{mem[rbank][3][k[1:0]][11]}}, mem[rbank][3][k[1:0]]};
      va = v0 + v3;
      vb = v1 + v2;
      vc = v1 - v2;
      vd = v0 - v3;
      y = k[3:2] == 2'd0 ? va + vb :
          k[3:2] == 2'd1 ? (vd <<< 1) + vc :
          k[3:2] == 2'd2 ? va - vb : vd - (vc <<< 1);
   end
   // Rows 1-3 of a started block are always taken; only row 0 is gated by READY.
   always_comb begin
      ready_int = st[wbank] == EMPTY || st[wbank] == FILLING;
      accept = bus.enable && (rowcnt != 2'd0 || ready_int);
      fill_done = accept && rowcnt == 2'd3;
      drain_done = rd == RD_RUN && k == 4'd15;
      o = ~rbank;
      sel = st[wbank] == FULL ? wbank : ~wbank;
      start_idle = rd == RD_IDLE && (st[0] == FULL || st[1] == FULL);
      chain = drain_done && (st[o] == FULL || (fill_done && wbank == o));
      rd_nx = rd;
      k_nx = rd == RD_RUN ? k + 4'd1 : k;
      rbank_nx = rbank;
      if (drain_done) rd_nx = chain ? RD_RUN : RD_IDLE;
      if (chain) rbank_nx = o;
      if (start_idle) begin
         rd_nx = RD_RUN;
         rbank_nx = sel;
         k_nx = 4'd0;
      end
      for (int b = 0; b < 2; b++) begin
         st_nx[b] = st[b];
         if (drain_done && rbank == b[0]) st_nx[b] = EMPTY;
         if (accept && wbank == b[0]) st_nx[b] = fill_done ? FULL : FILLING;
         if ((start_idle && sel == b[0]) || (chain && o == b[0])) st_nx[b] = DRAINING;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         st[0] <= EMPTY;
         st[1] <= EMPTY;
         rd <= RD_IDLE;
         rowcnt <= 2'd0;
         wbank <= 1'b0;
         rbank <= 1'b0;
         k <= 4'd0;
         bus.valid <= 1'b0;
         bus.ynout <= 16'd0;
         bus.index <= 4'd0;
      end else begin
         st <= st_nx;
         rd <= rd_nx;
         k <= k_nx;
         rbank <= rbank_nx;
         if (accept) rowcnt <= rowcnt + 2'd1;
         if (fill_done) wbank <= ~wbank;
         bus.valid <= rd == RD_RUN;
         if (rd == RD_RUN) begin
            bus.ynout <= {y[14], y};
            bus.index <= k;
         end
      end
   end
   // Bank contents survive reset; only the bookkeeping is cleared.
   always_ff @(posedge clk) begin
      if (accept) for (int s = 0; s < 4; s++) mem[wbank][rowcnt][s] <= h[s];
   end
`ifdef H264_CT_DCOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.dcvalid <= 1'b0;
         bus.dcout <= 16'd0;
      end else begin
         bus.dcvalid <= rd == RD_RUN && k == 4'd0;
         if (rd == RD_RUN && k == 4'd0) bus.dcout <= {y[14], y};
      end
   end
`endif
endmodule

// File: tb/tb_h264_coretransform4x4.sv
// tb_h264_coretransform4x4: scoreboard bench for the 4x4 core transform.
module tb_h264_coretransform4x4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int t3 = 0;
   int run = 0;
   int last_run = 0;
   int qv[$];
   int qi[$];
   int cur[4][4];
   int ev, ei;
   h264_coretransform4x4_if bus();
   h264_coretransform4x4 dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (bus.valid) begin
         checks++;
         if (qv.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: index=%0d ynout=%0d, required no output", bus.index, $signed(bus.ynout));
         end else begin
            ev = qv.pop_front();
            ei = qi.pop_front();
            if (bus.ynout !== 16'(ev) || bus.index !== 4'(ei)) begin
               errors++;
               $display("FAIL coef: index=%0d ynout=%0d, required index=%0d ynout=%0d", bus.index, $signed(bus.ynout), ei, ev);
            end
`ifdef H264_CT_DCOUT_EN
            checks++;
            if (bus.dcvalid !== (ei == 0) || (ei == 0 && bus.dcout !== 16'(ev))) begin
               errors++;
               $display("FAIL dc_tap: dcvalid=%0b dcout=%0d at index %0d, required dcvalid=%0b dcout=%0d", bus.dcvalid, $signed(bus.dcout), ei, ei == 0, ev);
            end
`endif
         end
         run++;
      end else begin
         if (run > 0) last_run = run;
         run = 0;
      end
   end
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic push_expected;
      int c[4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            int acc = 0;
            for (int r = 0; r < 4; r++)
               for (int q = 0; q < 4; q++) acc += c[i][r] * cur[r][q] * c[j][q];
            qv.push_back(acc);
            qi.push_back(4 * i + j);
         end
   endtask
   task automatic send_block(input int gap);
      int n;
      for (int r = 0; r < 4; r++) begin
         if (r == 0 && !bus.ready) begin
            bus.enable = 1'b0;
            n = 0;
            while (!bus.ready && n < 300) begin
               step();
               n++;
            end
            checks++;
            if (!bus.ready) begin
               errors++;
               $display("FAIL ready_timeout: ready=%0b, required 1", bus.ready);
            end
         end
         bus.enable = 1'b1;
         bus.xxin = {9'(cur[r][3]), 9'(cur[r][2]), 9'(cur[r][1]), 9'(cur[r][0])};
         step();
         if (r == 3) begin
            push_expected();
            t3 = cyc;
         end
         if (gap > 0) begin
            bus.enable = 1'b0;
            repeat (gap) step();
         end
      end
   endtask
   task automatic wait_drain;
      int n = 0;
      bus.enable = 1'b0;
      while (qv.size() != 0 && n < 400) begin
         step();
         n++;
      end
      checks++;
      if (qv.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d outputs outstanding, required 0", qv.size());
      end
      repeat (2) step();
   endtask
   task automatic set_impulse;
      foreach (cur[r, c]) cur[r][c] = 0;
      cur[0][0] = 1;
   endtask
   task automatic set_random;
      foreach (cur[r, c]) cur[r][c] = int'($urandom_range(510)) - 255;
   endtask
   task automatic check_latency(input string name);
      int n = 0;
      while (!bus.valid && n < 10) begin
         step();
         n++;
      end
      checks++;
      if (!bus.valid || cyc - t3 != 2 || bus.index !== 4'd0) begin
         errors++;
         $display("FAIL %s_first: valid=%0b index=%0d after %0d cycles, required valid=1 index=0 after 2", name, bus.valid, bus.index, cyc - t3);
      end
      repeat (15) step();
      checks++;
      if (!bus.valid || bus.index !== 4'd15) begin
         errors++;
         $display("FAIL %s_last: valid=%0b index=%0d at t+17, required valid=1 index=15", name, bus.valid, bus.index);
      end
   endtask
   task automatic test_reset;
      bus.enable = 1'b0;
      bus.xxin = '0;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.ynout !== 16'd0 || bus.index !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle: ready=%0b valid=%0b ynout=%0h index=%0d, required 1 0 0 0", bus.ready, bus.valid, bus.ynout, bus.index);
         end
`ifdef H264_CT_DCOUT_EN
         checks++;
         if (bus.dcvalid !== 1'b0 || bus.dcout !== 16'd0) begin
            errors++;
            $display("FAIL reset_dc: dcvalid=%0b dcout=%0h, required 0 0", bus.dcvalid, bus.dcout);
         end
`endif
      end
   endtask
   task automatic test_impulse;
      set_impulse();
      send_block(0);
      bus.enable = 1'b0;
      check_latency("impulse");
      wait_drain();
   endtask
   task automatic test_flat;
      foreach (cur[r, c]) cur[r][c] = -255;
      send_block(0);
      wait_drain();
   endtask
   task automatic test_random;
      for (int b = 0; b < 3; b++) begin
         set_random();
         send_block(b);
         wait_drain();
      end
   endtask
   task automatic test_gapped;
      set_impulse();
      send_block(2);
      check_latency("gapped");
      wait_drain();
      set_random();
      send_block(2);
      wait_drain();
   endtask
   task automatic test_back_to_back;
      last_run = 0;
      set_random();
      send_block(0);
      set_random();
      send_block(0);
      checks++;
      if (bus.ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ready_low: ready=%0b after second fill, required 0", bus.ready);
      end
      bus.xxin = 36'h123456789;
      step();
      set_random();
      send_block(0);
      wait_drain();
      checks++;
      if (last_run != 48) begin
         errors++;
         $display("FAIL b2b_contiguous: valid run=%0d, required 48", last_run);
      end
   endtask
   task automatic test_reset_mid_drain;
      int n = 0;
      set_impulse();
      send_block(0);
      bus.enable = 1'b0;
      while (!(bus.valid && bus.index == 4'd6) && n < 30) begin
         step();
         n++;
      end
      reset = 1'b1;
      step();
      checks++;
      if (bus.valid !== 1'b0 || bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: valid=%0b ready=%0b, required valid=0 ready=1", bus.valid, bus.ready);
      end
      reset = 1'b0;
      qv.delete();
      qi.delete();
      step();
      set_impulse();
      send_block(0);
      bus.enable = 1'b0;
      check_latency("post_reset");
      wait_drain();
   endtask
   initial begin
      test_reset();
      test_impulse();
      test_flat();
      test_random();
      test_gapped();
      test_back_to_back();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
